// File: rtl/spi_mitm_bus.sv
// spi_mitm_bus: man-in-the-middle tap on a mode-0 SPI bus.
//
// In IDLE the block passes MOSI/MISO through untouched. Once a session is
// started it requests a word decision (eval), waits for the MITM logic to
// answer (eval_done), then shifts one word. During that word each direction
// carries either the real line or a latched fake word, and the real bits are
// captured. A finished word is published on real_*_data together with a fresh
// eval pulse.
//
// Ports
//   sys_clk, rst                  system clock, async active-high reset
//   bus_sclk, bus_cs_n            raw SPI clock / chip select from the master
//   mosi_in, miso_in              raw SPI data from master / slave
//   mosi_out, miso_out            SPI data toward slave / master
//   mitm_start, mitm_done         session start / end pulses
//   fake_mosi_data/_select        replacement word for MOSI and its enable
//   fake_miso_data/_select        replacement word for MISO and its enable
//   data_size                     word length in bits (1..MAX_DATA_SIZE)
//   eval_done                     MITM logic has set up the next word
//   real_mosi_data/real_miso_data last captured word, right-aligned
//   eval                          one-cycle request for the next word decision
//   busy, cfg_err, overrun        session active / sticky bad size / sticky overrun
//
// Build option: SPI_OVERRUN_DETECT_EN enables the sticky overrun flag for
// SCLK activity while no word is armed; without it overrun is tied low.
//
// state | meaning
// IDLE  | transparent pass-through, waiting for mitm_start
// PREP  | eval pulse to request the first word decision
// WAIT  | waiting for eval_done from the MITM logic
// LOAD  | latch fake words, selects and word size
// SHIFT | word in flight: inject/capture on SCLK edges

module spi_mitm_bus #(
    parameter int MAX_DATA_SIZE   = 9,
    parameter int DATA_SIZE_WIDTH = $clog2(MAX_DATA_SIZE + 1)
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    input  logic                       bus_sclk,
    input  logic                       bus_cs_n,
    input  logic                       mosi_in,
    input  logic                       miso_in,
    output logic                       mosi_out,
    output logic                       miso_out,
    input  logic                       mitm_start,
    input  logic                       mitm_done,
    input  logic [MAX_DATA_SIZE-1:0]   fake_miso_data,
    input  logic [MAX_DATA_SIZE-1:0]   fake_mosi_data,
    input  logic [DATA_SIZE_WIDTH-1:0] data_size,
    input  logic                       fake_miso_select,
    input  logic                       fake_mosi_select,
    input  logic                       eval_done,
    output logic [MAX_DATA_SIZE-1:0]   real_miso_data,
    output logic [MAX_DATA_SIZE-1:0]   real_mosi_data,
    output logic                       eval,
    output logic                       busy,
    output logic                       cfg_err,
    output logic                       overrun
);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_WAIT, S_LOAD, S_SHIFT} state_t;

    state_t r_state, w_state_nxt;

    logic [1:0] r_sclk_sync, r_cs_sync, r_mosi_sync, r_miso_sync;
    logic       r_sclk_d, r_cs_d;

    logic [MAX_DATA_SIZE-1:0]   r_fake_mosi, r_fake_miso, r_cap_mosi, r_cap_miso;
    logic                       r_fake_mosi_sel, r_fake_miso_sel;
    logic [DATA_SIZE_WIDTH-1:0] r_size, r_bit_cnt, r_idx;
    logic                       r_eval, r_cfg_err;

    logic w_sclk_rise, w_sclk_fall, w_cs_low, w_cs_rise, w_size_bad;

    // Synchronizers reset to an idle bus so no spurious edge appears at release.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= 2'b00;
            r_cs_sync   <= 2'b11;
            r_mosi_sync <= 2'b00;
            r_miso_sync <= 2'b00;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], bus_sclk};
            r_cs_sync   <= {r_cs_sync[0], bus_cs_n};
            r_mosi_sync <= {r_mosi_sync[0], mosi_in};
            r_miso_sync <= {r_miso_sync[0], miso_in};
            r_sclk_d    <= r_sclk_sync[1];
            r_cs_d      <= r_cs_sync[1];
        end
    end

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_d;
    assign w_cs_low    = ~r_cs_sync[1];
    assign w_cs_rise   = r_cs_sync[1] & ~r_cs_d;
    assign w_size_bad  = (data_size == '0) ||
                         (data_size > DATA_SIZE_WIDTH'(MAX_DATA_SIZE));

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (mitm_start) w_state_nxt = S_PREP;
            S_PREP:  w_state_nxt = S_WAIT;
            S_WAIT:  if (eval_done) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = w_size_bad ? S_IDLE : S_SHIFT;
            S_SHIFT: if (r_bit_cnt == '0) w_state_nxt = S_WAIT;
            default: w_state_nxt = S_IDLE;
        endcase
        if (mitm_done) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_fake_mosi     <= '0;
            r_fake_miso     <= '0;
            r_fake_mosi_sel <= 1'b0;
            r_fake_miso_sel <= 1'b0;
            r_size          <= '0;
            r_bit_cnt       <= '0;
            r_idx           <= '0;
            r_cap_mosi      <= '0;
            r_cap_miso      <= '0;
            real_mosi_data  <= '0;
            real_miso_data  <= '0;
            r_eval          <= 1'b0;
            r_cfg_err       <= 1'b0;
        end else begin
            // Registered so the word-done pulse lines up with the new real_*_data.
            r_eval <= ((r_state == S_IDLE)  && (w_state_nxt == S_PREP)) ||
                      ((r_state == S_SHIFT) && (w_state_nxt == S_WAIT));
            case (r_state)
                S_IDLE: begin
                    if (mitm_start) r_cfg_err <= 1'b0;
                end
                S_LOAD: begin
                    r_fake_mosi     <= fake_mosi_data;
                    r_fake_miso     <= fake_miso_data;
                    r_fake_mosi_sel <= fake_mosi_select;
                    r_fake_miso_sel <= fake_miso_select;
                    r_size          <= data_size;
                    r_bit_cnt       <= data_size;
                    r_idx           <= data_size - DATA_SIZE_WIDTH'(1);
                    r_cap_mosi      <= '0;
                    r_cap_miso      <= '0;
                    if (w_size_bad) r_cfg_err <= 1'b1;
                end
                S_SHIFT: begin
                    if (r_bit_cnt == '0) begin
                        if (w_state_nxt == S_WAIT) begin
                            real_mosi_data <= r_cap_mosi;
                            real_miso_data <= r_cap_miso;
                        end
                    end else if (w_cs_rise) begin
                        // Master abandoned the word: rearm for a full retry.
                        r_cap_mosi <= '0;
                        r_cap_miso <= '0;
                        r_bit_cnt  <= r_size;
                        r_idx      <= r_size - DATA_SIZE_WIDTH'(1);
                    end else if (w_cs_low) begin
                        if (w_sclk_rise) begin
                            r_cap_mosi <= {r_cap_mosi[MAX_DATA_SIZE-2:0], r_mosi_sync[1]};
                            r_cap_miso <= {r_cap_miso[MAX_DATA_SIZE-2:0], r_miso_sync[1]};
                            r_bit_cnt  <= r_bit_cnt - DATA_SIZE_WIDTH'(1);
                        end
                        if (w_sclk_fall && (r_idx != '0)) r_idx <= r_idx - DATA_SIZE_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SPI_OVERRUN_DETECT_EN
    logic r_overrun;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if ((r_state == S_IDLE) && mitm_start) begin
            r_overrun <= 1'b0;
        end else if (((r_state == S_PREP) || (r_state == S_WAIT) || (r_state == S_LOAD)) &&
                     w_sclk_rise && w_cs_low) begin
            r_overrun <= 1'b1;
        end
    end

    assign overrun = r_overrun;
`else
    assign overrun = 1'b0;
`endif

    // Injection only while a word is armed; every other state is transparent.
    always_comb begin
        mosi_out = mosi_in;
        miso_out = miso_in;
        if (r_state == S_SHIFT) begin
            if (r_fake_mosi_sel) mosi_out = r_fake_mosi[r_idx];
            if (r_fake_miso_sel) miso_out = r_fake_miso[r_idx];
        end
    end

    assign eval    = r_eval;
    assign busy    = (r_state != S_IDLE);
    assign cfg_err = r_cfg_err;

endmodule

// File: doc/spi_mitm_bus.md
SPI_MITM_BUS -- requirements
Module: spi_mitm_bus

Interface
REQ-001 Parameter MAX_DATA_SIZE, default 9: widest SPI word, in bits, that the block captures or injects.
REQ-002 Parameter DATA_SIZE_WIDTH, default $clog2(MAX_DATA_SIZE+1): width of data_size.
REQ-003 sys_clk  in  1  system clock; all state on its rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 bus_sclk, bus_cs_n, mosi_in, miso_in  in  1 each  raw SPI lines from master/slave (mode 0).
REQ-006 mosi_out, miso_out  out  1 each  SPI lines driven toward slave/master.
REQ-007 mitm_start, mitm_done  in  1 each  single-cycle session start/end pulses, shared with the MITM logic block.
REQ-008 fake_miso_data, fake_mosi_data  in  MAX_DATA_SIZE each; data_size  in  DATA_SIZE_WIDTH; fake_miso_select, fake_mosi_select  in  1 each; eval_done  in  1.
REQ-009 real_miso_data, real_mosi_data  out  MAX_DATA_SIZE each  last captured word, right-aligned, upper bits zero.
REQ-010 eval  out  1  single-cycle request to evaluate the next word.
REQ-011 busy, cfg_err, overrun  out  1 each  session active / sticky bad data_size / sticky overrun.

Function
REQ-012 bus_sclk, bus_cs_n, mosi_in, miso_in SHALL pass through a 2-FF synchronizer; SCLK edges are detected on the synchronized signal; bus_sclk frequency SHALL be at most sys_clk/8.
REQ-013 FSM states SHALL be IDLE, PREP, WAIT, LOAD, SHIFT; busy = (state != IDLE).
REQ-014 IDLE: mosi_out = mosi_in, miso_out = miso_in (combinational, raw); mitm_start -> PREP.
REQ-015 PREP: eval high for exactly one cycle -> WAIT.
REQ-016 WAIT: hold; on eval_done -> LOAD.
REQ-017 LOAD (one cycle): latch fake data, selects, data_size; bit counter := data_size; fake bit index := data_size-1; -> SHIFT. data_size = 0 or > MAX_DATA_SIZE: set cfg_err, -> IDLE.
REQ-018 SHIFT: mosi_out = fake_mosi_select ? latched fake_mosi_data[index] : mosi_in; miso_out likewise with fake_miso_*.
REQ-019 SHIFT, CS low, SCLK rising edge: shift synchronized mosi/miso into capture registers MSB-first (first wire bit lands in bit data_size-1); decrement counter.
REQ-020 SHIFT, CS low, SCLK falling edge: decrement fake bit index (no change once at 0).
REQ-021 Counter reaching 0: next cycle copy capture registers to real_*_data, pulse eval for one cycle, -> WAIT.
REQ-022 CS rising in SHIFT mid-word: discard partial capture, counter := latched data_size, index := data_size-1, stay SHIFT, no eval.
REQ-023 SCLK rising edge with CS low while in WAIT, PREP or LOAD SHALL be an overrun (bit ignored).
REQ-024 mitm_done in any state -> IDLE next cycle, overriding all other transitions; mitm_start outside IDLE ignored.
REQ-025 eval_done outside WAIT ignored; simultaneous mitm_done and eval_done: mitm_done wins.

Reset
REQ-026 rst asserted: state IDLE, eval 0, real_*_data 0, capture registers 0, cfg_err 0, overrun 0, synchronizers to idle bus (sclk 0, cs_n 1, data 0); outputs pass through.
REQ-027 rst mid-session SHALL abort immediately with no eval pulse after release.
REQ-028 cfg_err and overrun clear only on rst or mitm_start.

Configuration
REQ-029 Macro SPI_OVERRUN_DETECT_EN defined: REQ-023 sets sticky overrun and the FSM continues.
REQ-030 Macro SPI_OVERRUN_DETECT_EN undefined: overrun tied 0, no detection logic, early bits silently ignored.

Verification
REQ-031 mitm_start, eval_done after 5 cycles with data_size=3, selects 0; master sends MOSI 110 -> one PREP eval pulse, then eval with real_mosi_data=9'h006, outputs equal inputs.
REQ-032 data_size=8, fake_miso_data=8'h5A, fake_miso_select=1, slave drives 8'hD9 -> master sees 5A on miso_out, real_miso_data=9'h0D9.
REQ-033 data_size=8, CS raised after 4 bits, then full byte 8'hA2 -> exactly one eval, real_mosi_data=9'h0A2.
REQ-034 data_size=0 at LOAD -> cfg_err=1, busy=0, passthrough resumes.
REQ-035 SCLK edge while in WAIT with macro defined -> overrun=1; undefined -> overrun stays 0.
REQ-036 mitm_done and rst each asserted mid-word -> IDLE, no eval pulse, passthrough within one cycle.
